riscv_irq_arbiter: RTL and testbench

RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

---
 rtl/riscv_irq_arbiter.sv | 129 ++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_irq_arbiter.sv
// Fixed-priority interrupt arbiter: per-source edge/level capture feeding a
// three-state offer handshake towards the core interrupt controller.

module riscv_irq_src (
  input  logic clk,
  input  logic rst_n,
  input  logic setback_i,
  input  logic line_i,
  input  logic edge_cfg_i,
  input  logic mask_i,
  input  logic clr_i,
  output logic pending_o,
  output logic req_o
);
  logic prev_q, pend_q, pend_d;

  // A fresh edge beats an ack-clear on the same cycle.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | (edge_cfg_i & line_i & ~prev_q);
    if (setback_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= line_i;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
  assign req_o     = mask_i & (edge_cfg_i ? pend_q : line_i);
endmodule

module riscv_irq_arbiter #(
  parameter bit PULP_SECURE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        setback_i,
  input  logic [31:0] irq_lines_i,
  input  logic [31:0] irq_edge_cfg_i,
  input  logic [31:0] irq_mask_i,
  input  logic [31:0] irq_sec_cfg_i,
  input  logic        irq_ack_i,
  input  logic        irq_kill_i,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_sec_o,
  output logic [31:0] pending_o
);
  localparam int NUM_SRC = 32;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [4:0]         id_q, id_d, win_id;
  logic               sec_q, sec_d, ack_clr;
  logic [NUM_SRC-1:0] req;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    riscv_irq_src u_src (
      .clk        (clk),
      .rst_n      (rst_n),
      .setback_i  (setback_i),
      .line_i     (irq_lines_i[i]),
      .edge_cfg_i (irq_edge_cfg_i[i]),
      .mask_i     (irq_mask_i[i]),
      .clr_i      (ack_clr && (id_q == 5'(i))),
      .pending_o  (pending_o[i]),
      .req_o      (req[i])
    );
  end

  // Ascending scan: the last hit is the highest index.
  always_comb begin
    win_id = 5'd0;
    for (int i = 0; i < NUM_SRC; i++)
      if (req[i]) win_id = 5'(i);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    ack_clr = 1'b0;
    case (state_q)
      S_IDLE: if (|req) begin
        id_d    = win_id;
        sec_d   = irq_sec_cfg_i[win_id];
        state_d = S_OFFER;
      end
      S_OFFER: begin
        if (irq_ack_i) begin
          ack_clr = 1'b1;
          state_d = S_CLEAR;
        end else if (irq_kill_i || !req[id_q]) begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (setback_i) begin
      state_d = S_IDLE;
      id_d    = 5'd0;
      sec_d   = 1'b0;
      ack_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= 5'd0;
      sec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sec_q   <= sec_d;
    end
  end

  assign irq_o     = (state_q == S_OFFER);
  assign irq_id_o  = id_q;
  assign irq_sec_o = PULP_SECURE ? sec_q : 1'b0;
endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Directed bench for riscv_irq_arbiter; a secure and a non-secure instance
// share every input.

module tb_riscv_irq_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, setback, ack, kill;
  logic [31:0] lines, edge_cfg, mask, sec_cfg;
  logic        irq, sec, irq0, sec0;
  logic [4:0]  id, id0;
  logic [31:0] pend, pend0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  riscv_irq_arbiter #(.PULP_SECURE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_lines_i(lines),
    .irq_edge_cfg_i(edge_cfg), .irq_mask_i(mask), .irq_sec_cfg_i(sec_cfg),
    .irq_ack_i(ack), .irq_kill_i(kill), .irq_o(irq), .irq_id_o(id),
    .irq_sec_o(sec), .pending_o(pend));

  riscv_irq_arbiter #(.PULP_SECURE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_lines_i(lines),
    .irq_edge_cfg_i(edge_cfg), .irq_mask_i(mask), .irq_sec_cfg_i(sec_cfg),
    .irq_ack_i(ack), .irq_kill_i(kill), .irq_o(irq0), .irq_id_o(id0),
    .irq_sec_o(sec0), .pending_o(pend0));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; setback = 1'b0; ack = 1'b0; kill = 1'b0;
    lines = '0; edge_cfg = '0; mask = '1; sec_cfg = '0;
    #3;
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b exp 0", irq); end
    n_chk++; if (id !== 5'd0) begin n_fail++; $display("FAIL rst_id: got %0d exp 0", id); end
    n_chk++; if (sec !== 1'b0) begin n_fail++; $display("FAIL rst_sec: got %0b exp 0", sec); end
    n_chk++; if (pend !== 32'h0) begin n_fail++; $display("FAIL rst_pend: got %h exp 0", pend); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %0b exp 0", irq); end
  endtask

  task automatic test_priority();
    lines[3] = 1'b1; lines[17] = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd17) begin n_fail++; $display("FAIL prio_offer: got irq=%0b id=%0d exp irq=1 id=17", irq, id); end
    ack = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0 || id !== 5'd17) begin n_fail++; $display("FAIL prio_clear: got irq=%0b id=%0d exp irq=0 id=17", irq, id); end
    ack = 1'b0; lines[17] = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %0b exp 0", irq); end
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd3) begin n_fail++; $display("FAIL prio_next: got irq=%0b id=%0d exp irq=1 id=3", irq, id); end
    ack = 1'b1; lines = '0;
    cyc();
    ack = 1'b0;
    cyc(); cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prio_drain: got %0b exp 0", irq); end
  endtask

  task automatic test_edge_pending();
    edge_cfg[5] = 1'b1; lines[5] = 1'b1;
    cyc();
    n_chk++; if (pend !== 32'h20 || irq !== 1'b0) begin n_fail++; $display("FAIL edge_pend: got pend=%h irq=%0b exp pend=20 irq=0", pend, irq); end
    lines[5] = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd5) begin n_fail++; $display("FAIL edge_offer: got irq=%0b id=%0d exp irq=1 id=5", irq, id); end
    ack = 1'b1;
    cyc();
    n_chk++; if (pend !== 32'h0) begin n_fail++; $display("FAIL edge_ackclr: got %h exp 0", pend); end
    ack = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_noreoffer1: got %0b exp 0", irq); end
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_noreoffer2: got %0b exp 0", irq); end
  endtask

  task automatic test_set_wins();
    lines[5] = 1'b1;
    cyc();
    lines[5] = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd5) begin n_fail++; $display("FAIL setw_offer: got irq=%0b id=%0d exp irq=1 id=5", irq, id); end
    lines[5] = 1'b1; ack = 1'b1;
    cyc();
    n_chk++; if (pend !== 32'h20 || irq !== 1'b0) begin n_fail++; $display("FAIL setw_pend: got pend=%h irq=%0b exp pend=20 irq=0", pend, irq); end
    lines[5] = 1'b0; ack = 1'b0;
    cyc(); cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd5) begin n_fail++; $display("FAIL setw_reoffer: got irq=%0b id=%0d exp irq=1 id=5", irq, id); end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc();
    n_chk++; if (pend !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL setw_done: got pend=%h irq=%0b exp pend=0 irq=0", pend, irq); end
    edge_cfg = '0;
  endtask

  task automatic test_kill_withdraw();
    lines[9] = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd9) begin n_fail++; $display("FAIL kill_offer: got irq=%0b id=%0d exp irq=1 id=9", irq, id); end
    kill = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL kill_idle: got %0b exp 0", irq); end
    kill = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd9) begin n_fail++; $display("FAIL kill_reoffer: got irq=%0b id=%0d exp irq=1 id=9", irq, id); end
    mask[9] = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL withdraw: got %0b exp 0", irq); end
    mask[9] = 1'b1;
    cyc();
    ack = 1'b1; kill = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ackkill_clear: got %0b exp 0", irq); end
    ack = 1'b0; kill = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ackkill_prec: got %0b exp 0", irq); end
    lines = '0;
    cyc();
  endtask

  task automatic test_secure();
    sec_cfg[2] = 1'b1; lines[2] = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd2 || sec !== 1'b1) begin n_fail++; $display("FAIL sec_on: got irq=%0b id=%0d sec=%0b exp 1/2/1", irq, id, sec); end
    n_chk++; if (irq0 !== 1'b1 || id0 !== 5'd2 || sec0 !== 1'b0) begin n_fail++; $display("FAIL sec_off: got irq=%0b id=%0d sec=%0b exp 1/2/0", irq0, id0, sec0); end
    lines = '0;
    cyc();
    n_chk++; if (irq !== 1'b0 || id !== 5'd2 || sec !== 1'b1) begin n_fail++; $display("FAIL sec_hold: got irq=%0b id=%0d sec=%0b exp 0/2/1", irq, id, sec); end
    sec_cfg = '0;
  endtask

  task automatic test_setback();
    edge_cfg[4] = 1'b1; edge_cfg[7] = 1'b1;
    lines[4] = 1'b1; lines[7] = 1'b1;
    cyc(); cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd7 || pend !== 32'h90) begin n_fail++; $display("FAIL sb_pre: got irq=%0b id=%0d pend=%h exp 1/7/90", irq, id, pend); end
    setback = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0 || pend !== 32'h0 || id !== 5'd0 || sec !== 1'b0) begin n_fail++; $display("FAIL sb_flush: got irq=%0b pend=%h id=%0d sec=%0b exp 0/0/0/0", irq, pend, id, sec); end
    setback = 1'b0;
    cyc();
    n_chk++; if (irq !== 1'b0 || pend !== 32'h0) begin n_fail++; $display("FAIL sb_static1: got irq=%0b pend=%h exp 0/0", irq, pend); end
    cyc();
    n_chk++; if (irq !== 1'b0 || pend !== 32'h0) begin n_fail++; $display("FAIL sb_static2: got irq=%0b pend=%h exp 0/0", irq, pend); end
    lines = '0; edge_cfg = '0;
    cyc();
  endtask

  task automatic test_reset_mid_offer();
    lines[12] = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b1 || id !== 5'd12) begin n_fail++; $display("FAIL rmo_offer: got irq=%0b id=%0d exp 1/12", irq, id); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (irq !== 1'b0 || id !== 5'd0 || sec !== 1'b0 || pend !== 32'h0) begin n_fail++; $display("FAIL rmo_async: got irq=%0b id=%0d sec=%0b pend=%h exp all 0", irq, id, sec, pend); end
    lines = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rmo_after: got %0b exp 0", irq); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_edge_pending();
    test_set_wins();
    test_kill_withdraw();
    test_secure();
    test_setback();
    test_reset_mid_offer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
